// File: rtl/alu_share_ctrl_pkg.sv
// Shared definitions for the ALU sharing controller: ALU opcodes, FSM state
// encodings and the bit positions of the captured compare flags.
package alu_share_ctrl_pkg;

  // ALU opcodes. The controller forwards them unchanged; the ALU decodes them.
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_MUL  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_HALF = 3'b100;
  localparam logic [2:0] ALU_GT   = 3'b101;
  localparam logic [2:0] ALU_LT   = 3'b110;
  localparam logic [2:0] ALU_SUB  = 3'b111;

  // Controller FSM state encodings.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Bit positions inside rsp_flags.
  localparam int FLAG_Z   = 2;
  localparam int FLAG_AGB = 1;
  localparam int FLAG_BGA = 0;

  // Assemble the response flag field from the individual ALU flags.
  function automatic logic [2:0] pack_flags(input logic z, input logic agb, input logic bga);
    logic [2:0] f;
    f           = '0;
    f[FLAG_Z]   = z;
    f[FLAG_AGB] = agb;
    f[FLAG_BGA] = bga;
    return f;
  endfunction

endpackage

// File: rtl/alu_share_ctrl_rr_arbiter.sv
// rr_arbiter: purely combinational round-robin arbiter. The search starts one
// position after last_grant and wraps modulo NUM_REQ; the first requester with
// req set receives a one-hot grant. enable low forces grant to zero.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant
);

  // Walk the requesters in rotated priority order and grant the first valid one.
  always_comb begin
    int   idx;
    logic found;
    // NOTE: every variable assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = int'(last_grant) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (enable && !found && (idx == j) && req[j]) begin
          grant[j] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: shares one combinational 16-bit ALU among NUM_REQ requesters.
// A round-robin winner's (op, A, B) is registered onto the ALU inputs, the
// result and compare flags are captured one cycle later, and the response is
// held with the owner's ID until the consumer accepts it.
// Optional feature: define ALU_PERF_CNT_EN to build the saturating perf_ops
// counter of completed operations; otherwise perf_ops is tied to zero.
module alu_share_ctrl
  import alu_share_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [3*NUM_REQ-1:0]    req_op,
  input  logic [16*NUM_REQ-1:0]   req_a,
  input  logic [16*NUM_REQ-1:0]   req_b,
  output logic [2:0]              alu_op,
  output logic [15:0]             alu_a,
  output logic [15:0]             alu_b,
  input  logic [15:0]             alu_d_out,
  input  logic                    alu_z,
  input  logic                    alu_agb,
  input  logic                    alu_bga,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [15:0]             rsp_data,
  output logic [2:0]              rsp_flags,
  output logic                    busy,
  output logic [31:0]             perf_ops
);

  logic [1:0]         state;
  logic [ID_W-1:0]    last_grant;
  logic [ID_W-1:0]    grant_id;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    win_id;
  logic [2:0]         win_op;
  logic [15:0]        win_a;
  logic [15:0]        win_b;
  logic               accept;
  logic               rsp_fire;

  // Arbitration only runs in IDLE; reset also forces req_ready low so every
  // output reads zero while rst_n is asserted.
  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .enable     ((state == ST_IDLE) && rst_n),
    .grant      (grant)
  );

  assign req_ready = grant;
  assign accept    = |grant;
  assign rsp_fire  = rsp_valid & rsp_ready;
  assign busy      = (state != ST_IDLE);

  // Select the winning requester's ID and payload from the packed buses.
  always_comb begin
    win_id = '0;
    win_op = '0;
    win_a  = '0;
    win_b  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        win_id = ID_W'(i);
        win_op = req_op[3*i +: 3];
        win_a  = req_a[16*i +: 16];
        win_b  = req_b[16*i +: 16];
      end
    end
  end

  // Control FSM: latch command in IDLE, capture ALU result in EXEC, hold the
  // response in RESP until it is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last_grant <= ID_W'(NUM_REQ - 1);
      grant_id   <= '0;
      alu_op     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_data   <= '0;
      rsp_flags  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      case (state)
        ST_IDLE: begin
          if (accept) begin
            alu_op   <= win_op;
            alu_a    <= win_a;
            alu_b    <= win_b;
            grant_id <= win_id;
            state    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_data  <= alu_d_out;
          rsp_flags <= pack_flags(alu_z, alu_agb, alu_bga);
          rsp_id    <= grant_id;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_fire) begin
            rsp_valid  <= 1'b0;
            last_grant <= grant_id;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ALU_PERF_CNT_EN
  // Count completed response handshakes, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_ops <= '0;
    end else if (rsp_fire && (perf_ops != 32'hFFFF_FFFF)) begin
      perf_ops <= perf_ops + 32'd1;
    end
  end
`else
  assign perf_ops = 32'h0;
`endif

endmodule
